// File: rtl/registro_puntaje_multi_pkg.sv
// Shared definitions for the basket score register: sound FSM encoding and
// default parameter values.
package registro_puntaje_multi_pkg;

   typedef enum logic {
      SND_IDLE = 1'b0,
      SND_PLAY = 1'b1
   } snd_state_e;

   localparam int DEF_N_CH       = 5;
   localparam int DEF_SCORE_W    = 9;
   localparam int DEF_SND_LEN    = 4;
   localparam int DEF_LEVEL_STEP = 10;

endpackage

// File: rtl/registro_puntaje_multi_contador_unos.sv
// Purely combinational population count of an N_CH-bit vector.
module contador_unos #(
   parameter int N_CH  = 5,
   parameter int CNT_W = $clog2(N_CH) + 1
) (
   input  logic [N_CH-1:0]  bits_i,
   output logic [CNT_W-1:0] count_o
);

   // Sum of set bits.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < N_CH; i++) begin
         count_o = count_o + CNT_W'(bits_i[i]);
      end
   end

endmodule

// File: rtl/registro_puntaje_multi.sv
// Multi-channel catch score register with stretched sound pulse and level-up
// tracking. Define REGISTRO_PUNTAJE_BONUS_EN to add one bonus point on multi-catch cycles.
module registro_puntaje_multi
   import registro_puntaje_multi_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int SCORE_W    = DEF_SCORE_W,
   parameter int SND_LEN    = DEF_SND_LEN,
   parameter int LEVEL_STEP = DEF_LEVEL_STEP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [N_CH-1:0]    pulsos_cubos_canasta,
   output logic [SCORE_W-1:0] puntaje,
   output logic               pulso_sonido,
   output logic               nuevo_nivel,
   output logic               saturado
);

   localparam int CNT_W = $clog2(N_CH) + 1;
   localparam int SND_W = (SND_LEN > 1) ? $clog2(SND_LEN) : 1;
   localparam int SW1   = SCORE_W + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
   localparam logic [SW1-1:0]     SCORE_MAXX = {1'b0, SCORE_MAX};
   localparam logic [SW1-1:0]     STEP_X     = SW1'(LEVEL_STEP);
   // One past SCORE_MAX: a threshold the score can never reach.
   localparam logic [SW1-1:0]     THR_SAT    = {1'b1, {SCORE_W{1'b0}}};
   localparam logic [SW1-1:0]     THR_INIT   =
      (LEVEL_STEP > (2 ** SCORE_W) - 1) ? THR_SAT : SW1'(LEVEL_STEP);
   localparam logic [SND_W-1:0]   SND_RELOAD = SND_W'(SND_LEN - 1);

   logic [N_CH-1:0]    edge_d, edge_q;
   logic [SCORE_W-1:0] puntaje_d, puntaje_q;
   logic [SW1-1:0]     next_thr_d, next_thr_q;
   logic               nuevo_nivel_d, nuevo_nivel_q;
   snd_state_e         state_d, state_q;
   logic [SND_W-1:0]   snd_cnt_d, snd_cnt_q;

   logic [N_CH-1:0]    hit_s;
   logic [CNT_W-1:0]   hit_cnt_s;
   logic               scoring_s;
   logic [SW1-1:0]     add_s;
   logic [SW1-1:0]     sum_s;
   logic [SCORE_W-1:0] sat_sum_s;

   contador_unos #(
      .N_CH  (N_CH),
      .CNT_W (CNT_W)
   ) u_contador_unos (
      .bits_i  (hit_s),
      .count_o (hit_cnt_s)
   );

   // Rising-edge detection, points to add and saturating sum.
   always_comb begin
      edge_d    = pulsos_cubos_canasta;
      hit_s     = pulsos_cubos_canasta & ~edge_q;
      scoring_s = enable && (hit_cnt_s != '0);
`ifdef REGISTRO_PUNTAJE_BONUS_EN
      if (SW1'(hit_cnt_s) >= SW1'(2)) begin
         add_s = SW1'(hit_cnt_s) + SW1'(1);
      end else begin
         add_s = SW1'(hit_cnt_s);
      end
`else
      add_s = SW1'(hit_cnt_s);
`endif
      sum_s = {1'b0, puntaje_q} + add_s;
      if (sum_s > SCORE_MAXX) begin
         sat_sum_s = SCORE_MAX;
      end else begin
         sat_sum_s = sum_s[SCORE_W-1:0];
      end
   end

   // Score, level threshold and sound FSM next state.
   always_comb begin
      puntaje_d     = puntaje_q;
      next_thr_d    = next_thr_q;
      nuevo_nivel_d = 1'b0;
      state_d       = state_q;
      snd_cnt_d     = snd_cnt_q;
      if (clear) begin
         puntaje_d  = '0;
         next_thr_d = THR_INIT;
         state_d    = SND_IDLE;
         snd_cnt_d  = '0;
      end else if (scoring_s) begin
         puntaje_d = sat_sum_s;
         state_d   = SND_PLAY;
         snd_cnt_d = SND_RELOAD;
         if (next_thr_q <= {1'b0, sat_sum_s}) begin
            nuevo_nivel_d = 1'b1;
            // Park the threshold out of reach once another step would overflow.
            if (next_thr_q > (SCORE_MAXX - STEP_X)) begin
               next_thr_d = THR_SAT;
            end else begin
               next_thr_d = next_thr_q + STEP_X;
            end
         end else begin
            next_thr_d = next_thr_q;
         end
      end else if (enable) begin
         case (state_q)
            SND_PLAY: begin
               if (snd_cnt_q == '0) begin
                  state_d = SND_IDLE;
               end else begin
                  snd_cnt_d = snd_cnt_q - SND_W'(1);
               end
            end
            SND_IDLE: begin
               state_d = SND_IDLE;
            end
            default: begin
               state_d   = SND_IDLE;
               snd_cnt_d = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q        <= '1;
         puntaje_q     <= '0;
         next_thr_q    <= THR_INIT;
         nuevo_nivel_q <= 1'b0;
         state_q       <= SND_IDLE;
         snd_cnt_q     <= '0;
      end else begin
         edge_q        <= edge_d;
         puntaje_q     <= puntaje_d;
         next_thr_q    <= next_thr_d;
         nuevo_nivel_q <= nuevo_nivel_d;
         state_q       <= state_d;
         snd_cnt_q     <= snd_cnt_d;
      end
   end

   assign puntaje      = puntaje_q;
   assign pulso_sonido = (state_q == SND_PLAY);
   assign nuevo_nivel  = nuevo_nivel_q;
   assign saturado     = (puntaje_q == SCORE_MAX);

endmodule

// File: tb/tb_registro_puntaje_multi.sv
// Self-checking bench for registro_puntaje_multi: cycle model plus directed
// literal checks.
module tb_registro_puntaje_multi;

   localparam int N_CH       = 5;
   localparam int SCORE_W    = 9;
   localparam int SND_LEN    = 4;
   localparam int LEVEL_STEP = 10;
   localparam int SMAX       = (1 << SCORE_W) - 1;
`ifdef REGISTRO_PUNTAJE_BONUS_EN
   localparam int BONUS = 1;
`else
   localparam int BONUS = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic enable = 1'b0;
   logic [N_CH-1:0] pulsos = '0;
   logic [SCORE_W-1:0] puntaje;
   logic pulso_sonido, nuevo_nivel, saturado;

   int n_pass = 0;
   int n_checks = 0;

   int m_score, m_thr, m_left;
   logic m_lvl;
   logic [N_CH-1:0] m_prev;
   int nx_score, nx_thr, nx_left;
   logic nx_lvl;

   always #5 clk = ~clk;

   registro_puntaje_multi #(
      .N_CH       (N_CH),
      .SCORE_W    (SCORE_W),
      .SND_LEN    (SND_LEN),
      .LEVEL_STEP (LEVEL_STEP)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .clear                (clear),
      .enable               (enable),
      .pulsos_cubos_canasta (pulsos),
      .puntaje              (puntaje),
      .pulso_sonido         (pulso_sonido),
      .nuevo_nivel          (nuevo_nivel),
      .saturado             (saturado)
   );

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int pts(input int c);
      return c + ((c >= 2) ? BONUS : 0);
   endfunction

   // Model: score as an integer, sound as "cycles of pulse still to come".
   always @* begin : model_next
      int c;
      c = $countones(pulsos & ~m_prev);
      nx_score = m_score;
      nx_thr   = m_thr;
      nx_left  = m_left;
      nx_lvl   = 1'b0;
      if (clear) begin
         nx_score = 0;
         nx_thr   = LEVEL_STEP;
         nx_left  = 0;
      end else if (enable && c > 0) begin
         nx_score = (m_score + pts(c) > SMAX) ? SMAX : m_score + pts(c);
         if (m_thr <= SMAX && nx_score >= m_thr) begin
            nx_lvl = 1'b1;
            nx_thr = m_thr + LEVEL_STEP;
         end
         nx_left = SND_LEN;
      end else if (enable && m_left > 0) begin
         nx_left = m_left - 1;
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_score <= 0;
         m_thr   <= LEVEL_STEP;
         m_left  <= 0;
         m_lvl   <= 1'b0;
         m_prev  <= '1;
      end else begin
         m_score <= nx_score;
         m_thr   <= nx_thr;
         m_left  <= nx_left;
         m_lvl   <= nx_lvl;
         m_prev  <= pulsos;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("m_puntaje", int'(puntaje), m_score);
         chk("m_pulso", int'(pulso_sonido), int'(m_left > 0));
         chk("m_nivel", int'(nuevo_nivel), int'(m_lvl));
         chk("m_saturado", int'(saturado), int'(m_score == SMAX));
      end
   end

   task automatic step(input logic [N_CH-1:0] p, input logic en, input logic clr);
      pulsos = p;
      enable = en;
      clear  = clr;
      @(negedge clk);
   endtask

   initial begin
      int expv;
      int cnt;
      logic [N_CH-1:0] pats [10];
      reset  = 1'b0;
      pulsos = '1;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_puntaje", int'(puntaje), 0);
      chk("rst_pulso", int'(pulso_sonido), 0);
      chk("rst_nivel", int'(nuevo_nivel), 0);
      chk("rst_saturado", int'(saturado), 0);
      reset = 1'b1;

      // Inputs already high at reset release do not count.
      step(5'b11111, 1'b1, 1'b0);
      step(5'b11111, 1'b1, 1'b0);
      chk("held_at_release", int'(puntaje), 0);
      step(5'b00000, 1'b1, 1'b0);

      step(5'b00001, 1'b1, 1'b0);
      chk("single_hit", int'(puntaje), 1);
      cnt = pulso_sonido ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         step(5'b00000, 1'b1, 1'b0);
         if (pulso_sonido) cnt++;
      end
      chk("snd_len4", cnt, 4);

      step(5'b10101, 1'b1, 1'b0);
      expv = 1 + 3 + BONUS;
      chk("three_hits", int'(puntaje), expv);
      repeat (8) step(5'b00000, 1'b1, 1'b0);

      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(5'b00010, 1'b1, 1'b0);
         if (pulso_sonido) cnt++;
      end
      expv = expv + 1;
      chk("held_once", int'(puntaje), expv);
      chk("held_snd_len", cnt, 4);
      repeat (2) step(5'b00000, 1'b1, 1'b0);

      pats = '{5'b00100, 5'b00000, 5'b01000, 5'b00000, 5'b00000,
               5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(pats[i], 1'b1, 1'b0);
         if (pulso_sonido) cnt++;
      end
      expv = expv + 2;
      chk("retrig_len6", cnt, 6);
      chk("retrig_score", int'(puntaje), expv);

      step(5'b00000, 1'b1, 1'b1);
      chk("clear_score", int'(puntaje), 0);
      for (int i = 0; i < 9; i++) begin
         step(5'b00001, 1'b1, 1'b0);
         step(5'b00000, 1'b1, 1'b0);
      end
      chk("preload9", int'(puntaje), 9);
      step(5'b10101, 1'b1, 1'b0);
      expv = 12 + BONUS;
      chk("lvl_score12", int'(puntaje), expv);
      chk("lvl_pulse", int'(nuevo_nivel), 1);
      step(5'b00000, 1'b1, 1'b0);
      chk("lvl_one_cycle", int'(nuevo_nivel), 0);
      for (int i = 0; i < 20 && expv < 20; i++) begin
         step(5'b00001, 1'b1, 1'b0);
         expv++;
         chk("lvl_thr20", int'(nuevo_nivel), int'(expv == 20));
         step(5'b00000, 1'b1, 1'b0);
      end
      chk("reach20", int'(puntaje), 20);

      step(5'b00000, 1'b1, 1'b1);
      expv = 0;
      for (int i = 0; i < 200 && expv + 5 + BONUS <= 510; i++) begin
         step(5'b11111, 1'b1, 1'b0);
         step(5'b00000, 1'b1, 1'b0);
         expv = expv + 5 + BONUS;
      end
      for (int i = 0; i < 10 && expv < 510; i++) begin
         step(5'b00001, 1'b1, 1'b0);
         step(5'b00000, 1'b1, 1'b0);
         expv++;
      end
      chk("preload510", int'(puntaje), 510);
      chk("not_sat510", int'(saturado), 0);
      step(5'b10101, 1'b1, 1'b0);
      chk("sat_score", int'(puntaje), 511);
      chk("sat_flag", int'(saturado), 1);
      step(5'b00000, 1'b1, 1'b0);
      step(5'b00001, 1'b1, 1'b0);
      chk("sat_keep", int'(puntaje), 511);
      chk("sat_sound", int'(pulso_sonido), 1);

      // Asynchronous reset in the middle of the sound pulse.
      #2 reset = 1'b0;
      #1;
      chk("async_pulso", int'(pulso_sonido), 0);
      chk("async_score", int'(puntaje), 0);
      pulsos = '0;
      @(negedge clk);
      reset = 1'b1;
      step(5'b00000, 1'b1, 1'b0);
      step(5'b01000, 1'b1, 1'b1);
      chk("clear_prio_score", int'(puntaje), 0);
      chk("clear_prio_snd", int'(pulso_sonido), 0);

      step(5'b00000, 1'b1, 1'b0);
      step(5'b00100, 1'b0, 1'b0);
      chk("disabled_score", int'(puntaje), 0);
      chk("disabled_snd", int'(pulso_sonido), 0);
      step(5'b00100, 1'b1, 1'b0);
      chk("edge_lost", int'(puntaje), 0);
      step(5'b00000, 1'b1, 1'b0);
      step(5'b00100, 1'b1, 1'b0);
      chk("after_enable", int'(puntaje), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/registro_puntaje_multi.md
REGISTRO_PUNTAJE_MULTI -- requirements
Module: registro_puntaje_multi

Interface
REQ-001 SHALL have parameter N_CH, default 5: number of basket catch channels.
REQ-002 SHALL have parameter SCORE_W, default 9: score width in bits; SCORE_MAX = 2^SCORE_W-1.
REQ-003 SHALL have parameter SND_LEN, default 4: sound pulse length in clk cycles, minimum 1.
REQ-004 SHALL have parameter LEVEL_STEP, default 10: points per level, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous new-game clear, active-high.
REQ-008 SHALL have port enable, input, 1 bit: when low, scoring is frozen.
REQ-009 SHALL have port pulsos_cubos_canasta, input, N_CH bits: per-channel catch indication.
REQ-010 SHALL have port puntaje, output, SCORE_W bits: registered score.
REQ-011 SHALL have port pulso_sonido, output, 1 bit: registered, stretched sound request.
REQ-012 SHALL have port nuevo_nivel, output, 1 bit: one-cycle level-up pulse.
REQ-013 SHALL have port saturado, output, 1 bit: high while puntaje == SCORE_MAX.

Function
REQ-014 SHALL register pulsos_cubos_canasta every cycle and define hit[i] = input high now and low last cycle; a held-high input SHALL count once.
REQ-015 SHALL compute the hit count as the population count of hit, sized to log2(N_CH)+1 bits.
REQ-016 When enable=1 and the hit count is nonzero, the edge sampling the hit SHALL load puntaje with old + count, saturating at SCORE_MAX; latency is one edge.
REQ-017 When enable=0, puntaje, level tracking and the sound FSM SHALL NOT change; the edge-detect register SHALL keep sampling, so edges occurring while disabled are lost.
REQ-018 The sound FSM SHALL have two states: IDLE (pulso_sonido=0) and PLAY (pulso_sonido=1) with a down-counter.
REQ-019 IDLE->PLAY on any counted hit, counter loaded with SND_LEN-1; PLAY->IDLE when the counter is 0 and there is no new hit.
REQ-020 A counted hit while in PLAY SHALL reload the counter with SND_LEN-1 (retrigger); the pulse is not restarted.
REQ-021 A hit while saturated SHALL still trigger sound; the score SHALL stay at SCORE_MAX.
REQ-022 The block SHALL hold next_thr, reset to LEVEL_STEP; when the updated score >= next_thr, nuevo_nivel SHALL be 1 for that cycle and next_thr SHALL be increased by LEVEL_STEP.
REQ-023 There SHALL be at most one nuevo_nivel per cycle even if one update crosses multiple thresholds; remaining thresholds fire on later scoring cycles.
REQ-024 next_thr SHALL saturate and no further nuevo_nivel SHALL occur once next_thr would exceed SCORE_MAX.
REQ-025 clear=1 SHALL have priority over enable and hits: it zeroes puntaje, returns the FSM to IDLE, zeroes nuevo_nivel and restores next_thr.

Reset
REQ-026 On reset low, puntaje=0, pulso_sonido=0, nuevo_nivel=0, FSM=IDLE, next_thr=LEVEL_STEP and the edge register is all-ones, so levels already high at release do not count.
REQ-027 Reset assertion mid-PLAY SHALL drop pulso_sonido immediately and asynchronously.

Configuration
REQ-028 With macro REGISTRO_PUNTAJE_BONUS_EN defined, a cycle with hit count >= 2 SHALL add count+1 points; without it, the block adds exactly count points.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, PLAY) and the default parameter constants.
REQ-030 The population count SHALL be a sub-module named contador_unos, parameterised by N_CH and purely combinational.

Verification
REQ-031 Defaults, bonus off: the single-cycle pattern 5'b00001 gives puntaje=1 after one edge and pulso_sonido high for exactly 4 cycles.
REQ-032 Applying 5'b10101 in one cycle gives +3; with the bonus macro defined it gives +4.
REQ-033 Holding 5'b00010 high for 20 cycles gives +1 only; a second hit 2 cycles into PLAY extends the pulse to 6 cycles total.
REQ-034 Starting at puntaje=9, a +3 hit gives puntaje=12, nuevo_nivel high 1 cycle and next_thr=20.
REQ-035 Preloading to 510 and then a +3 hit gives puntaje=511 and saturado=1; a further hit keeps 511 and still sounds.
REQ-036 Reset low mid-PLAY drops pulso_sonido at once; clear and a hit in the same cycle gives puntaje=0.
